// File: rtl/ex_if.sv
// ex_if: bundle between the ID/EX register, the execute stage and the EX/MEM consumers.
// E-side: control (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE),
//         operands (RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE), forwarding (ForwardAE, ForwardBE, ResultW).
// Branch: PCSrcE, PCTargetE back to fetch.
// M-side: RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM.
// Counters InstrCount/TakenCount exist only when EX_PERF_CNT_EN is defined.
interface ex_if;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
`ifdef EX_PERF_CNT_EN
    logic [31:0] InstrCount, TakenCount;
`endif

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
               PCPlus4M, RdM
`ifdef EX_PERF_CNT_EN
        , InstrCount, TakenCount
`endif
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM,
               PCPlus4M, RdM
`ifdef EX_PERF_CNT_EN
        , InstrCount, TakenCount
`endif
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RISC-V execute stage - operand forwarding, ALU, branch resolution, EX/MEM register.
// Ports: clock, reset (async, active-high), enable (EX/MEM load, 0 = stall),
//        flush (sync bubble, wins over enable), bus (ex_if.slave: E-side in, branch and M-side out).
// Optional: define EX_PERF_CNT_EN for saturating InstrCount/TakenCount performance counters.
module ex_stage (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic flush,
    ex_if.slave  bus
);
    logic [31:0] SrcAE, SrcBE, WriteDataE, ALUResultE;
    logic        PCSrcE;

    // Forwarding from ALUResultM reads the registered value, so it stays valid during a stall.
    always_comb begin
        SrcAE      = bus.ForwardAE == 2'b10 ? bus.ALUResultM : bus.ForwardAE == 2'b01 ? bus.ResultW : bus.RD1E;
        WriteDataE = bus.ForwardBE == 2'b10 ? bus.ALUResultM : bus.ForwardBE == 2'b01 ? bus.ResultW : bus.RD2E;
        SrcBE      = bus.ALUSrcE ? bus.ImmExtE : WriteDataE;
        case (bus.ALUControlE)
            3'b000:  ALUResultE = SrcAE + SrcBE;
            3'b001:  ALUResultE = SrcAE - SrcBE;
            3'b010:  ALUResultE = SrcAE & SrcBE;
            3'b011:  ALUResultE = SrcAE | SrcBE;
            3'b100:  ALUResultE = SrcAE ^ SrcBE;
            3'b101:  ALUResultE = {31'b0, $signed(SrcAE) < $signed(SrcBE)};
            default: ALUResultE = '0;
        endcase
        PCSrcE = (bus.BranchE & (ALUResultE == '0)) | bus.JumpE;
    end

    // Not qualified by enable/flush; the hazard unit does that.
    assign bus.PCSrcE    = PCSrcE;
    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.RdM        <= '0;
            bus.PCPlus4M   <= '0;
        end else if (enable) begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.ResultSrcM <= bus.ResultSrcE;
            bus.ALUResultM <= ALUResultE;
            bus.WriteDataM <= WriteDataE;
            bus.RdM        <= bus.RdE;
            bus.PCPlus4M   <= bus.PCPlus4E;
        end
    end

`ifdef EX_PERF_CNT_EN
    logic [31:0] instr_cnt, taken_cnt;
    logic        advance, valid;

    assign advance = enable & ~flush;
    assign valid   = bus.RegWriteE | bus.MemWriteE | bus.BranchE | bus.JumpE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_cnt <= '0;
            taken_cnt <= '0;
        end else if (advance) begin
            if (valid && instr_cnt != '1) instr_cnt <= instr_cnt + 32'd1;
            if (PCSrcE && taken_cnt != '1) taken_cnt <= taken_cnt + 32'd1;
        end
    end

    assign bus.InstrCount = instr_cnt;
    assign bus.TakenCount = taken_cnt;
`else
    // Counters and their ports are absent in this build.
`endif
endmodule
